// File: rtl/conv_pkg.sv
// Shared constants and FSM encoding for the
// convolution frame driver.
package conv_pkg;

  localparam int IFM_W   = 16;
  localparam int OFM_W   = 36;
  localparam int IFM_N   = 49;
  localparam int WGT_N   = 9;
  localparam int OFM_N   = 25;
  localparam int TIMEOUT = 64;

  localparam logic [5:0] IFM_NC   = 6'(IFM_N);
  localparam logic [5:0] WGT_NC   = 6'(WGT_N);
  localparam logic [4:0] OFM_NC   = 5'(OFM_N);
  localparam logic [4:0] K_LAST   = 5'(OFM_N - 1);
  localparam logic [6:0] TMO_LAST = 7'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_COLLECT,
    S_DRAIN
  } state_t;

endpackage

// File: rtl/conv_result_buf.sv
// 25-entry OFM result store: one write port,
// registered read port, async clear.
module conv_result_buf
  import conv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [4:0]       i_waddr,
  input  logic [OFM_W-1:0] i_wdata,
  input  logic [4:0]       i_raddr,
  output logic [OFM_W-1:0] o_rdata
);

  logic [OFM_W-1:0] r_mem [OFM_N];
  logic [OFM_W-1:0] r_rdata;

  // result write, cleared on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OFM_N; i++)
        r_mem[i] <= '0;
    end else if (i_we && i_waddr < OFM_NC) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // registered read, zero beyond last entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_rdata <= '0;
    else if (i_raddr < OFM_NC)
      r_rdata <= r_mem[i_raddr];
    else
      r_rdata <= '0;
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/conv_frame_driver.sv
// Host-side frame driver: buffers one IFM/weight
// frame, streams it to the engine, captures OFMs.
module conv_frame_driver
  import conv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_en,
  input  logic             ld_sel,
  input  logic [5:0]       ld_addr,
  input  logic [IFM_W-1:0] ld_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err_timeout,
  output logic             err_short,
  input  logic [4:0]       rd_addr,
  output logic [OFM_W-1:0] rd_data,
  output logic             conv_in_valid,
  output logic             conv_weight_valid,
  output logic [IFM_W-1:0] conv_ifm,
  output logic [IFM_W-1:0] conv_weight,
  input  logic             conv_out_valid,
  input  logic [OFM_W-1:0] conv_ofm
);

  state_t r_state, w_state_nx;

  logic [IFM_W-1:0] r_ifm [IFM_N];
  logic [IFM_W-1:0] r_wgt [WGT_N];

  logic [5:0] r_cnt, w_cnt_nx;
  logic [4:0] r_k,   w_k_nx;
  logic [6:0] r_tmo, w_tmo_nx;

  logic r_busy, w_busy_nx;
  logic r_done, w_done_nx;
  logic r_eto,  w_eto_nx;
  logic r_esh,  w_esh_nx;
  logic r_iv,   w_iv_nx;
  logic r_wv,   w_wv_nx;

  logic [IFM_W-1:0] r_cifm, w_cifm_nx;
  logic [IFM_W-1:0] r_cwgt, w_cwgt_nx;

  logic             w_we;
  logic [4:0]       w_waddr;
  logic             w_ld_ifm;
  logic             w_ld_wgt;
  logic [IFM_W-1:0] w_ifm0;
  logic [IFM_W-1:0] w_wgt0;

  assign w_ld_ifm = ld_en && !ld_sel
                 && ld_addr < IFM_NC
                 && r_state == S_IDLE;
  assign w_ld_wgt = ld_en && ld_sel
                 && ld_addr < WGT_NC
                 && r_state == S_IDLE;

  // word 0 goes out on the start edge, so a
  // same-cycle load of address 0 must bypass
  assign w_ifm0 = (w_ld_ifm && ld_addr == '0)
                ? ld_data : r_ifm[0];
  assign w_wgt0 = (w_ld_wgt && ld_addr == '0)
                ? ld_data : r_wgt[0];

  // host loads into IFM/weight buffers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IFM_N; i++)
        r_ifm[i] <= '0;
      for (int i = 0; i < WGT_N; i++)
        r_wgt[i] <= '0;
    end else begin
      if (w_ld_ifm)
        r_ifm[ld_addr] <= ld_data;
      if (w_ld_wgt)
        r_wgt[ld_addr[3:0]] <= ld_data;
    end
  end

  // FSM state, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_k     <= '0;
      r_tmo   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_eto   <= 1'b0;
      r_esh   <= 1'b0;
      r_iv    <= 1'b0;
      r_wv    <= 1'b0;
      r_cifm  <= '0;
      r_cwgt  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_k     <= w_k_nx;
      r_tmo   <= w_tmo_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
      r_eto   <= w_eto_nx;
      r_esh   <= w_esh_nx;
      r_iv    <= w_iv_nx;
      r_wv    <= w_wv_nx;
      r_cifm  <= w_cifm_nx;
      r_cwgt  <= w_cwgt_nx;
    end
  end

  // next-state, counter and output decode
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_k_nx     = r_k;
    w_tmo_nx   = r_tmo;
    w_busy_nx  = r_busy;
    w_done_nx  = 1'b0;
    w_eto_nx   = r_eto;
    w_esh_nx   = r_esh;
    w_iv_nx    = 1'b0;
    w_wv_nx    = 1'b0;
    w_cifm_nx  = '0;
    w_cwgt_nx  = '0;
    w_we       = 1'b0;
    w_waddr    = r_k;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nx = S_SEND;
          w_busy_nx  = 1'b1;
          w_eto_nx   = 1'b0;
          w_esh_nx   = 1'b0;
          w_iv_nx    = 1'b1;
          w_cifm_nx  = w_ifm0;
          w_wv_nx    = 1'b1;
          w_cwgt_nx  = w_wgt0;
          w_cnt_nx   = 6'd1;
        end
      end
      S_SEND: begin
        if (r_cnt < IFM_NC) begin
          w_iv_nx   = 1'b1;
          w_cifm_nx = r_ifm[r_cnt];
          w_cnt_nx  = r_cnt + 6'd1;
          if (r_cnt < WGT_NC) begin
            w_wv_nx   = 1'b1;
            w_cwgt_nx = r_wgt[r_cnt[3:0]];
          end
        end else begin
          // the first WAIT cycle already counts
          w_state_nx = S_WAIT;
          w_tmo_nx   = 7'd1;
        end
      end
      S_WAIT: begin
        if (conv_out_valid) begin
          w_we       = 1'b1;
          w_waddr    = '0;
          w_k_nx     = 5'd1;
          w_state_nx = S_COLLECT;
        end else if (r_tmo == TMO_LAST) begin
          w_eto_nx   = 1'b1;
          w_done_nx  = 1'b1;
          w_busy_nx  = 1'b0;
          w_state_nx = S_IDLE;
        end else begin
          w_tmo_nx = r_tmo + 7'd1;
        end
      end
      S_COLLECT: begin
        if (conv_out_valid) begin
          w_we   = 1'b1;
          w_k_nx = r_k + 5'd1;
          if (r_k == K_LAST) begin
            w_state_nx = S_DRAIN;
            w_tmo_nx   = '0;
          end
        end else begin
          w_esh_nx   = 1'b1;
          w_done_nx  = 1'b1;
          w_busy_nx  = 1'b0;
          w_state_nx = S_IDLE;
        end
      end
      S_DRAIN: begin
        // two idle cycles: engine counter cleared
        if (conv_out_valid) begin
          w_tmo_nx = '0;
        end else if (r_tmo[0]) begin
          w_done_nx  = 1'b1;
          w_busy_nx  = 1'b0;
          w_state_nx = S_IDLE;
        end else begin
          w_tmo_nx = 7'd1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  conv_result_buf u_res (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (conv_ofm),
    .i_raddr (rd_addr),
    .o_rdata (rd_data)
  );

  assign busy              = r_busy;
  assign done              = r_done;
  assign err_timeout       = r_eto;
  assign err_short         = r_esh;
  assign conv_in_valid     = r_iv;
  assign conv_weight_valid = r_wv;
  assign conv_ifm          = r_cifm;
  assign conv_weight       = r_cwgt;

endmodule
